mel_sparse_sched: RTL
=====================

// Module: mel_sparse_sched
// PURPOSE
//  Sequencer for the mel filterbank MAC/log datapath (mul_fp_clk -> add_fp_clk -> log_fp_clk).
//  Visits only each triangular filter's non-zero bins, read from a per-filter table ROM.
//  Replaces the full-half-frame sweep per filter with start/length bin ranges.
//  Sits between the frame controller (start/done) and the mel memories, coefficient ROM and log unit.
// PARAMETERS
//  ADDR_WIDTH      12  spectrum bin address / length width
//  COEF_ADDR_WIDTH 15  packed coefficient ROM address width
//  MEL_WIDTH       6   filter index width (up to 63 filters)
// PORTS
//  clk        in  1    clock, rising edge
//  rst_n      in  1    reset, asynchronous, active-low
//  start      in  1    1-cycle pulse: begin one frame; ignored while busy=1
//  mel_num    in  6    number of filters; sampled on accepted start
//  busy       out 1    high from accepted start until the cycle done pulses
//  done       out 1    1-cycle pulse after the last filter's write
//  tbl_addr   out 6    filter table address (= filter index m)
//  tbl_data   in  24   {start_bin[23:12], len[11:0]}; valid 1 cycle after tbl_addr
//  spec_addr  out 12   power-spectrum read address
//  coef_addr  out 15   coefficient ROM read address
//  rd_vld     out 1    spec_addr/coef_addr valid this cycle
//  acc_first  out 1    with rd_vld: first bin of filter (adder input 2 selects 0)
//  acc_last   out 1    with rd_vld: last bin of filter
//  acc_done   in  1    datapath pulse: final filter sum stable at adder output
//  log_req    out 1    request log of current sum; held until log_ack
//  log_ack    in  1    1-cycle pulse: log result valid
//  wr_en      out 1    1-cycle mel memory write strobe
//  wr_addr    out 12   write address = {6'd0, m}
//  wr_zero    out 1    with wr_en: empty filter, datapath writes LOG_FLOOR instead of log output
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; m=0; coef pointer=0.
//  States: IDLE -> TBL -> TBL_WAIT -> ISSUE -> DRAIN -> LOG -> WRITE -> (TBL | FIN) -> IDLE.
//  IDLE: on start: latch mel_num, m=0, coef_ptr=0, busy=1; if mel_num==0 go FIN.
//  TBL: tbl_addr=m (1 cycle). TBL_WAIT: latch start_bin,len from tbl_data.
//   len==0 -> skip to WRITE with wr_zero=1; no rd_vld, no log_req.
//  ISSUE: exactly len cycles, rd_vld=1 every cycle, no bubbles.
//   spec_addr = start_bin + k (k=0..len-1, mod 2^12); coef_addr = coef_ptr + k (mod 2^15).
//   acc_first at k=0, acc_last at k=len-1; both high when len==1.
//   Exit: coef_ptr += len (mod 2^15, packed coefficient layout across filters).
//  DRAIN: wait for acc_done; acc_done outside DRAIN is ignored.
//  LOG: log_req=1 until the cycle log_ack=1; log_req drops the cycle after ack.
//   ack in same cycle log_req rises is accepted.
//  WRITE: wr_en=1 for 1 cycle, wr_addr=m; then m+1; m+1==mel_num_latched -> FIN, else TBL.
//  FIN: done=1 one cycle, busy=0 same cycle; back to IDLE. start in FIN ignored.
//  Per-filter latency (len>0): 2 + len + drain + log + 1 cycles.
//  Range checks (start_bin+len beyond fft_num/2) are the table generator's job; no clamp.
//  rst_n low mid-frame: immediate return to reset values; no done pulse, no write.
// STRUCTURE
//  mel_sched_pkg: state enum (3-bit), field offsets TBL_START_MSB/LSB, TBL_LEN_MSB/LSB,
//   width constants.
//  Sub-module mel_issue_cnt: loadable down-counter with k index;
//   emits first/last/over for ISSUE.
//  Rest (FSM, coef_ptr, m counter, output regs) inline; all outputs registered.
// TESTING
//  mel_num=0, start -> done 2 cycles later, no rd_vld/wr_en, busy high exactly those cycles.
//  1 filter {start=5,len=3} -> spec 5,6,7; coef 0,1,2 on consecutive cycles;
//   first at 5, last at 7; wr_addr=0.
//  3 filters len 4,0,2 -> coef 0..3 then 4,5; filter1 writes with wr_zero=1,
//   no log_req; done after wr_addr=2.
//  len=1 -> acc_first and acc_last same cycle; log_ack delayed 7 cycles -> log_req held 7 cycles.
//  start pulsed during ISSUE and FIN -> ignored, sequence unchanged;
//   rst_n low mid-ISSUE -> all outputs 0, next start restarts m=0.
//  start_bin=4094,len=4 -> spec_addr 4094,4095,0,1 (wrap);
//   coef_ptr 32766 + len 4 -> next filter starts at coef 2.

Source files
------------

// File: rtl/mel_sparse_sched_pkg.sv
// Shared types and constants for the sparse mel filterbank sequencer:
// state encoding, filter-table field layout and address widths.
package mel_sparse_sched_pkg;

    localparam int ADDR_WIDTH      = 12;
    localparam int COEF_ADDR_WIDTH = 15;
    localparam int MEL_WIDTH       = 6;
    localparam int TBL_WIDTH       = 2 * ADDR_WIDTH;

    // Filter table word: {start_bin, len}
    localparam int TBL_START_MSB = 23;
    localparam int TBL_START_LSB = 12;
    localparam int TBL_LEN_MSB   = 11;
    localparam int TBL_LEN_LSB   = 0;

    typedef logic [ADDR_WIDTH-1:0]      bin_t;
    typedef logic [COEF_ADDR_WIDTH-1:0] coef_t;
    typedef logic [MEL_WIDTH-1:0]       mel_t;
    typedef logic [TBL_WIDTH-1:0]       tbl_word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TBL      = 3'd1,
        ST_TBL_WAIT = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_LOG      = 3'd5,
        ST_WRITE    = 3'd6,
        ST_FIN      = 3'd7
    } sched_state_e;

    function automatic bin_t tbl_start_bin(input tbl_word_t word);
        return word[TBL_START_MSB:TBL_START_LSB];
    endfunction

    function automatic bin_t tbl_len(input tbl_word_t word);
        return word[TBL_LEN_MSB:TBL_LEN_LSB];
    endfunction

endpackage

// File: rtl/mel_sparse_sched_if.sv
// Bundle between the mel sequencer and its surroundings (frame controller,
// filter table, spectrum/coef memories, accumulator, log unit, mel memory).
interface mel_sparse_sched_if;
    import mel_sparse_sched_pkg::*;

    logic      start_i;
    mel_t      mel_num_i;
    logic      busy_o;
    logic      done_o;
    mel_t      tbl_addr_o;
    tbl_word_t tbl_data_i;
    bin_t      spec_addr_o;
    coef_t     coef_addr_o;
    logic      rd_vld_o;
    logic      acc_first_o;
    logic      acc_last_o;
    logic      acc_done_i;
    logic      log_req_o;
    logic      log_ack_i;
    logic      wr_en_o;
    bin_t      wr_addr_o;
    logic      wr_zero_o;

    modport master (
        input  start_i, mel_num_i, tbl_data_i, acc_done_i, log_ack_i,
        output busy_o, done_o, tbl_addr_o, spec_addr_o, coef_addr_o, rd_vld_o,
               acc_first_o, acc_last_o, log_req_o, wr_en_o, wr_addr_o, wr_zero_o
    );

    modport slave (
        output start_i, mel_num_i, tbl_data_i, acc_done_i, log_ack_i,
        input  busy_o, done_o, tbl_addr_o, spec_addr_o, coef_addr_o, rd_vld_o,
               acc_first_o, acc_last_o, log_req_o, wr_en_o, wr_addr_o, wr_zero_o
    );
endinterface

// File: rtl/mel_sparse_sched_issue_cnt.sv
// Beat counter for one filter's bin burst: loads the length, tracks the
// current bin index k and flags the last and next-to-last beats.
module mel_issue_cnt
    import mel_sparse_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    input  bin_t len_i,
    output bin_t k_o,
    output logic last_o,
    output logic next_last_o
);

    bin_t rem_q, rem_d;
    bin_t k_q, k_d;

    // rem_q counts beats still to present, including the one on the bus now
    always_comb begin
        rem_d = rem_q;
        k_d   = k_q;
        if (load_i) begin
            rem_d = len_i;
            k_d   = '0;
        end else if (en_i && (rem_q != '0)) begin
            rem_d = rem_q - bin_t'(1);
            k_d   = k_q + bin_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            k_q   <= '0;
        end else begin
            rem_q <= rem_d;
            k_q   <= k_d;
        end
    end

    assign k_o         = k_q;
    assign last_o      = (rem_q == bin_t'(1));
    assign next_last_o = (rem_q == bin_t'(2));

endmodule

// File: rtl/mel_sparse_sched.sv
// Mel filterbank sequencer: walks each filter's non-zero bin range from the
// table ROM, feeds the MAC datapath, then runs log and mel-memory write.
module mel_sparse_sched
    import mel_sparse_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mel_sparse_sched_if.master bus
);

    sched_state_e state_q, state_d;

    mel_t  m_q, m_d;
    mel_t  mel_num_q, mel_num_d;
    mel_t  tbl_addr_q, tbl_addr_d;
    bin_t  start_bin_q, start_bin_d;
    bin_t  len_q, len_d;
    bin_t  spec_addr_q, spec_addr_d;
    bin_t  wr_addr_q, wr_addr_d;
    coef_t coef_ptr_q, coef_ptr_d;
    coef_t coef_addr_q, coef_addr_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic rd_vld_q, rd_vld_d;
    logic first_q, first_d;
    logic last_q, last_d;
    logic log_req_q, log_req_d;
    logic wr_en_q, wr_en_d;
    logic wr_zero_q, wr_zero_d;

    logic cnt_load, cnt_en, cnt_last, cnt_next_last;
    bin_t cnt_k;
    bin_t tbl_start_w, tbl_len_w;
    mel_t m_inc;

    assign tbl_start_w = tbl_start_bin(bus.tbl_data_i);
    assign tbl_len_w   = tbl_len(bus.tbl_data_i);
    assign m_inc       = m_q + mel_t'(1);

    mel_issue_cnt u_issue_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (cnt_load),
        .en_i        (cnt_en),
        .len_i       (tbl_len_w),
        .k_o         (cnt_k),
        .last_o      (cnt_last),
        .next_last_o (cnt_next_last)
    );

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        mel_num_d   = mel_num_q;
        tbl_addr_d  = tbl_addr_q;
        start_bin_d = start_bin_q;
        len_d       = len_q;
        spec_addr_d = spec_addr_q;
        wr_addr_d   = wr_addr_q;
        coef_ptr_d  = coef_ptr_q;
        coef_addr_d = coef_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_vld_d    = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        log_req_d   = 1'b0;
        wr_en_d     = 1'b0;
        wr_zero_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mel_num_d  = bus.mel_num_i;
                    m_d        = '0;
                    tbl_addr_d = '0;
                    coef_ptr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = (bus.mel_num_i == '0) ? ST_FIN : ST_TBL;
                end
            end
            ST_TBL: begin
                state_d = ST_TBL_WAIT;
            end
            ST_TBL_WAIT: begin
                start_bin_d = tbl_start_w;
                len_d       = tbl_len_w;
                if (tbl_len_w == '0) begin
                    wr_en_d   = 1'b1;
                    wr_zero_d = 1'b1;
                    wr_addr_d = bin_t'(m_q);
                    state_d   = ST_WRITE;
                end else begin
                    // Present beat k=0 straight out of the table read
                    cnt_load    = 1'b1;
                    rd_vld_d    = 1'b1;
                    spec_addr_d = tbl_start_w;
                    coef_addr_d = coef_ptr_q;
                    first_d     = 1'b1;
                    last_d      = (tbl_len_w == bin_t'(1));
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_last) begin
                    coef_ptr_d = coef_ptr_q + coef_t'(len_q);
                    state_d    = ST_DRAIN;
                end else begin
                    cnt_en      = 1'b1;
                    rd_vld_d    = 1'b1;
                    spec_addr_d = start_bin_q + cnt_k + bin_t'(1);
                    coef_addr_d = coef_ptr_q + coef_t'(cnt_k) + coef_t'(1);
                    last_d      = cnt_next_last;
                end
            end
            ST_DRAIN: begin
                if (bus.acc_done_i) begin
                    log_req_d = 1'b1;
                    state_d   = ST_LOG;
                end
            end
            ST_LOG: begin
                if (bus.log_ack_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = bin_t'(m_q);
                    state_d   = ST_WRITE;
                end else begin
                    log_req_d = 1'b1;
                end
            end
            ST_WRITE: begin
                m_d        = m_inc;
                tbl_addr_d = m_inc;
                state_d    = (m_inc == mel_num_q) ? ST_FIN : ST_TBL;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            mel_num_q   <= '0;
            tbl_addr_q  <= '0;
            start_bin_q <= '0;
            len_q       <= '0;
            spec_addr_q <= '0;
            wr_addr_q   <= '0;
            coef_ptr_q  <= '0;
            coef_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            log_req_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            mel_num_q   <= mel_num_d;
            tbl_addr_q  <= tbl_addr_d;
            start_bin_q <= start_bin_d;
            len_q       <= len_d;
            spec_addr_q <= spec_addr_d;
            wr_addr_q   <= wr_addr_d;
            coef_ptr_q  <= coef_ptr_d;
            coef_addr_q <= coef_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            first_q     <= first_d;
            last_q      <= last_d;
            log_req_q   <= log_req_d;
            wr_en_q     <= wr_en_d;
            wr_zero_q   <= wr_zero_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.tbl_addr_o  = tbl_addr_q;
    assign bus.spec_addr_o = spec_addr_q;
    assign bus.coef_addr_o = coef_addr_q;
    assign bus.rd_vld_o    = rd_vld_q;
    assign bus.acc_first_o = first_q;
    assign bus.acc_last_o  = last_q;
    assign bus.log_req_o   = log_req_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_zero_o   = wr_zero_q;

endmodule
